multiboot_scheduler: RTL and testbench

//  Arbitrates reboot requests from NREQ sources (CPU register, keyboard hotkey, external pin) onto one ICAP MultiBoot writer.

---
 rtl/multiboot_pkg.sv | 29 ++
 rtl/multiboot_scheduler_req_sync_edge.sv | 37 +++
 rtl/multiboot_scheduler.sv | 252 +++++++++++++++++++++++++
 tb/tb_multiboot_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiboot_pkg.sv
// Shared definitions for the MultiBoot reboot scheduler.
//   state_t    : FSM state encoding (3 bits), also exported on the debug port
//   OPC_1X     : SPI single-lane read opcode
//   OPC_4X     : SPI quad-output read opcode
//   slot_addr  : slot number -> 24-bit SPI address, wraps modulo 2^24
package multiboot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT     = 3'd1,
    ST_HOLDOFF   = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT_ACK  = 3'd4,
    ST_WAIT_DONE = 3'd5,
    ST_ERROR     = 3'd6
  } state_t;

  localparam logic [7:0] OPC_1X = 8'h03;
  localparam logic [7:0] OPC_4X = 8'h6B;

  // All operands are 24 bits wide, so the multiply and the add both wrap
  // modulo 2^24 as the flash address space requires.
  function automatic logic [23:0] slot_addr(input logic [23:0] base,
                                            input logic [23:0] size,
                                            input logic [23:0] slot);
    return base + slot * size;
  endfunction

endpackage

// File: rtl/multiboot_scheduler_req_sync_edge.sv
// req_sync_edge: per-bit 2-flop synchroniser followed by a rising-edge
// detector. One instance covers all request lines.
// Ports:
//   clk    in  1  destination clock
//   rst_n  in  1  asynchronous active-low reset, clears every flop
//   d      in  W  asynchronous level inputs
//   rise   out W  one-cycle pulse per synchronised 0->1 transition
module req_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);

  logic [W-1:0] meta;
  logic [W-1:0] sync;
  logic [W-1:0] prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  // An input already high when reset is released reads as a fresh edge,
  // since the history flops come out of reset at 0.
  assign rise = sync & ~prev;

endmodule

// File: rtl/multiboot_scheduler.sv
// multiboot_scheduler: arbitrates reboot requests onto a single ICAP
// MultiBoot writer. A granted request is turned into an SPI address and a
// read opcode, held off for HOLDOFF cycles, then handed to the writer.
// Ports:
//   clk_icap    in  1           ICAP clock, only clock in the block
//   rst_n       in  1           asynchronous active-low reset
//   enable      in  1           arm; new requests ignored while low
//   req         in  NREQ        asynchronous level requests (rising edge = request)
//   req_slot    in  NREQ*SLOTW  slot per requester, [i*SLOTW +: SLOTW]
//   quad_mode   in  1           1: quad read opcode, 0: single read opcode
//   clear_err   in  1           clears sticky errors; leaves ERROR
//   mbt_busy    in  1           busy flag from the ICAP writer
//   mbt_reboot  out 1           one-cycle start pulse to the writer
//   spi_addr    out 24          target address, captured on IDLE->GRANT
//   spi_opcode  out 8           read opcode, captured with spi_addr
//   busy        out 1           high in every state except IDLE
//   grant_id    out 2           index of the last granted requester
//   err_timeout out 1           sticky: writer never acknowledged
//   err_badslot out 1           sticky: a request named an invalid slot
//   fsm_state   out 3           current FSM state (debug)
//
// Writer handshake: mbt_reboot is high for exactly one cycle (the START
// state). The writer acknowledges by raising mbt_busy within ACK_TMO cycles
// and lowers it when done; mbt_busy low again returns the block to IDLE.
// A missing acknowledge re-issues the start up to MAX_RETRY times.
module multiboot_scheduler
  import multiboot_pkg::*;
#(
  parameter int          NREQ      = 3,
  parameter int          SLOTW     = 4,
  parameter int          NUM_SLOTS = 12,
  parameter logic [23:0] BASE_ADDR = 24'h0,
  parameter logic [23:0] SLOT_SIZE = 24'h80000,
  parameter int          HOLDOFF   = 1024,
  parameter int          ACK_TMO   = 64,
  parameter int          MAX_RETRY = 2
) (
  input  logic                  clk_icap,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*SLOTW-1:0] req_slot,
  input  logic                  quad_mode,
  input  logic                  clear_err,
  input  logic                  mbt_busy,
  output logic                  mbt_reboot,
  output logic [23:0]           spi_addr,
  output logic [7:0]            spi_opcode,
  output logic                  busy,
  output logic [1:0]            grant_id,
  output logic                  err_timeout,
  output logic                  err_badslot,
  output state_t                fsm_state
);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int TW = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  // One extra bit so NUM_SLOTS == 2**SLOTW is still representable.
  localparam logic [SLOTW:0] NUM_SLOTS_V = (SLOTW + 1)'(NUM_SLOTS);

  state_t state, state_n;

  logic [NREQ-1:0]  req_rise;
  logic             win_valid;
  logic [1:0]       win_id;
  logic [SLOTW-1:0] win_slot;
  logic             slot_ok;

  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [RW-1:0] retry_cnt;

  logic take_grant;
  logic set_bad;
  logic set_tmo;
  logic load_hold;
  logic dec_hold;
  logic load_tmo;
  logic dec_tmo;
  logic inc_retry;
  logic clr_retry;

  req_sync_edge #(.W(NREQ)) u_sync (
    .clk   (clk_icap),
    .rst_n (rst_n),
    .d     (req),
    .rise  (req_rise)
  );

  // Fixed-priority arbiter: scanning from the top down lets the lowest
  // index with an edge overwrite the others. Losing edges are simply not
  // used, which is how same-cycle competitors get discarded.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    win_slot  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rise[i]) begin
        win_valid = 1'b1;
        win_id    = 2'(i);
        win_slot  = req_slot[i*SLOTW +: SLOTW];
      end
    end
  end

  assign slot_ok = ({1'b0, win_slot} < NUM_SLOTS_V);

  // Next-state and control strobes.
  always_comb begin
    state_n    = state;
    take_grant = 1'b0;
    set_bad    = 1'b0;
    set_tmo    = 1'b0;
    load_hold  = 1'b0;
    dec_hold   = 1'b0;
    load_tmo   = 1'b0;
    dec_tmo    = 1'b0;
    inc_retry  = 1'b0;
    clr_retry  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && win_valid) begin
          if (slot_ok) begin
            take_grant = 1'b1;
            state_n    = ST_GRANT;
          end else begin
            set_bad = 1'b1;
          end
        end
      end
      ST_GRANT: begin
        load_hold = 1'b1;
        state_n   = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (hold_cnt == '0) begin
          state_n = ST_START;
        end else begin
          dec_hold = 1'b1;
        end
      end
      ST_START: begin
        load_tmo = 1'b1;
        state_n  = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (mbt_busy) begin
          state_n = ST_WAIT_DONE;
        end else if (tmo_cnt == '0) begin
          if (retry_cnt < RW'(MAX_RETRY)) begin
            inc_retry = 1'b1;
            state_n   = ST_START;
          end else begin
            set_tmo = 1'b1;
            state_n = ST_ERROR;
          end
        end else begin
          dec_tmo = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!mbt_busy) begin
          clr_retry = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (clear_err) begin
          clr_retry = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_icap or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Counters.
  always_ff @(posedge clk_icap or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      tmo_cnt   <= '0;
      retry_cnt <= '0;
    end else begin
      if (load_hold) begin
        hold_cnt <= HW'(HOLDOFF - 1);
      end else if (dec_hold) begin
        hold_cnt <= hold_cnt - HW'(1);
      end

      if (load_tmo) begin
        tmo_cnt <= TW'(ACK_TMO - 1);
      end else if (dec_tmo) begin
        tmo_cnt <= tmo_cnt - TW'(1);
      end

      if (clr_retry) begin
        retry_cnt <= '0;
      end else if (inc_retry) begin
        retry_cnt <= retry_cnt + RW'(1);
      end
    end
  end

  // Grant capture: the target only changes on IDLE->GRANT, so the writer
  // sees a stable address through every retry.
  always_ff @(posedge clk_icap or negedge rst_n) begin
    if (!rst_n) begin
      spi_addr   <= '0;
      spi_opcode <= '0;
      grant_id   <= '0;
    end else if (take_grant) begin
      spi_addr   <= slot_addr(BASE_ADDR, SLOT_SIZE, 24'(win_slot));
      spi_opcode <= quad_mode ? OPC_4X : OPC_1X;
      grant_id   <= win_id;
    end
  end

  // Sticky error flags. A new error in the same cycle as clear_err wins,
  // so an event is never lost to a coincident clear.
  always_ff @(posedge clk_icap or negedge rst_n) begin
    if (!rst_n) begin
      err_badslot <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (set_bad) begin
        err_badslot <= 1'b1;
      end else if (clear_err) begin
        err_badslot <= 1'b0;
      end

      if (set_tmo) begin
        err_timeout <= 1'b1;
      end else if (clear_err) begin
        err_timeout <= 1'b0;
      end
    end
  end

  assign mbt_reboot = (state == ST_START);
  assign busy       = (state != ST_IDLE);
  assign fsm_state  = state;

endmodule

// File: tb/tb_multiboot_scheduler.sv
// Testbench for multiboot_scheduler: directed requests, expected grants
// queued at issue time and checked by a monitor on every mbt_reboot pulse.
module tb_multiboot_scheduler;
  import multiboot_pkg::*;

  localparam int NREQ      = 3;
  localparam int SLOTW     = 4;
  localparam int HOLDOFF   = 1024;
  localparam int ACK_TMO   = 64;
  localparam int MAX_RETRY = 2;

  logic                  clk_icap;
  logic                  rst_n;
  logic                  enable;
  logic [NREQ-1:0]       req;
  logic [NREQ*SLOTW-1:0] req_slot;
  logic                  quad_mode;
  logic                  clear_err;
  logic                  mbt_busy;
  logic                  mbt_reboot;
  logic [23:0]           spi_addr;
  logic [7:0]            spi_opcode;
  logic                  busy;
  logic [1:0]            grant_id;
  logic                  err_timeout;
  logic                  err_badslot;
  state_t                fsm_state;

  multiboot_scheduler dut (
    .clk_icap    (clk_icap),
    .rst_n       (rst_n),
    .enable      (enable),
    .req         (req),
    .req_slot    (req_slot),
    .quad_mode   (quad_mode),
    .clear_err   (clear_err),
    .mbt_busy    (mbt_busy),
    .mbt_reboot  (mbt_reboot),
    .spi_addr    (spi_addr),
    .spi_opcode  (spi_opcode),
    .busy        (busy),
    .grant_id    (grant_id),
    .err_timeout (err_timeout),
    .err_badslot (err_badslot),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk_icap = 1'b0;
  always #5 clk_icap = ~clk_icap;

  int cyc = 0;
  always @(posedge clk_icap) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  // Entry = {grant_id, spi_opcode, spi_addr} expected at a start pulse.
  logic [33:0] exp_q[$];
  int          pulse_cyc_q[$];
  int          pulse_count = 0;
  int          n_checks    = 0;
  int          n_errors    = 0;
  logic [33:0] mon_got;
  logic [33:0] mon_want;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every start pulse must match the oldest queued expectation.
  always @(negedge clk_icap) begin
    if (rst_n && mbt_reboot) begin
      pulse_count++;
      pulse_cyc_q.push_back(cyc);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_pulse: mbt_reboot=1 at cycle %0d with nothing expected", cyc);
      end else begin
        mon_got  = {grant_id, spi_opcode, spi_addr};
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want) begin
          n_errors++;
          $display("FAIL pulse_target: got id/opc/addr %0h expected %0h (cycle %0d)",
                   mon_got, mon_want, cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_icap);
    #1;
  endtask

  task automatic raise_req(input int idx, input logic [SLOTW-1:0] slot);
    req_slot[idx*SLOTW +: SLOTW] = slot;
    req[idx] = 1'b1;
  endtask

  task automatic wait_pulse(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (pulse_count < target && n < budget) begin
      @(negedge clk_icap);
      #1;
      n++;
    end
    if (pulse_count < target) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: pulse count %0d, needed %0d within %0d cycles", name, pulse_count, target, budget);
    end
  endtask

  // ICAP writer model: acknowledge after `delay` cycles, stay busy `hold`.
  task automatic respond(input int delay, input int hold);
    repeat (delay) @(posedge clk_icap);
    #1 mbt_busy = 1'b1;
    repeat (hold) @(posedge clk_icap);
    #1 mbt_busy = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int t0;
  int base;

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    req       = '0;
    req_slot  = '0;
    quad_mode = 1'b0;
    clear_err = 1'b0;
    mbt_busy  = 1'b0;

    repeat (3) @(posedge clk_icap);
    @(negedge clk_icap);
    check("rst_reboot",   mbt_reboot,  1'b0);
    check("rst_busy",     busy,        1'b0);
    check("rst_addr",     spi_addr,    24'h0);
    check("rst_opcode",   spi_opcode,  8'h00);
    check("rst_grant_id", grant_id,    2'd0);
    check("rst_err_tmo",  err_timeout, 1'b0);
    check("rst_err_bad",  err_badslot, 1'b0);
    check("rst_state",    fsm_state,   ST_IDLE);

    @(posedge clk_icap);
    #1 rst_n = 1'b1;
    enable = 1'b1;
    tick(2);

    // T1: req[1], slot 3, 1x read -> 3*0x80000 = 0x180000.
    // Edge reaches GRANT 3 clocks after the request; GRANT takes 1 clock and
    // HOLDOFF takes HOLDOFF clocks, so the pulse is HOLDOFF+4 clocks after.
    quad_mode = 1'b0;
    exp_q.push_back({2'd1, 8'h03, 24'h180000});
    raise_req(1, 4'd3);
    t0 = cyc;
    repeat (3) @(posedge clk_icap);
    @(negedge clk_icap);
    check("t1_state_grant", fsm_state,  ST_GRANT);
    check("t1_grant_id",    grant_id,   2'd1);
    check("t1_addr",        spi_addr,   24'h180000);
    check("t1_opcode",      spi_opcode, 8'h03);
    check("t1_busy",        busy,       1'b1);
    req[1] = 1'b0;
    wait_pulse(1, HOLDOFF + 50, "t1_pulse");
    if (pulse_count >= 1) check("t1_latency", pulse_cyc_q[0] - t0, HOLDOFF + 4);
    respond(5, 20);
    tick(2);
    check("t1_back_idle", fsm_state, ST_IDLE);
    check("t1_busy_low",  busy,      1'b0);

    // T2: req[0] (slot 5) and req[2] (slot 7) in the same cycle, quad read.
    // Also: an edge on req[1] and enable falling during holdoff.
    base = pulse_count;
    quad_mode = 1'b1;
    exp_q.push_back({2'd0, 8'h6B, 24'h280000});
    req_slot[0 +: SLOTW]       = 4'd5;
    req_slot[2*SLOTW +: SLOTW] = 4'd7;
    req = 3'b101;
    tick(3);
    @(negedge clk_icap);
    check("t2_grant_id", grant_id, 2'd0);
    req = '0;
    tick(200);
    enable = 1'b0;
    raise_req(1, 4'd2);
    tick(10);
    req[1] = 1'b0;
    check("t2_busy_enable_low", busy, 1'b1);
    wait_pulse(base + 1, HOLDOFF + 50, "t2_pulse");
    respond(2, 3);
    tick(HOLDOFF + 200);
    check("t2_single_pulse", pulse_count, base + 1);
    check("t2_idle", fsm_state, ST_IDLE);
    enable = 1'b1;

    // T3: slot 12 is out of range.
    base = pulse_count;
    raise_req(0, 4'd12);
    tick(4);
    check("t3_badslot_set", err_badslot, 1'b1);
    check("t3_busy_low",    busy,        1'b0);
    req[0] = 1'b0;
    tick(20);
    check("t3_no_pulse", pulse_count, base);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    check("t3_badslot_clr", err_badslot, 1'b0);

    // T4: requests ignored while enable is low.
    enable = 1'b0;
    raise_req(0, 4'd1);
    tick(6);
    check("t4_ignored", busy, 1'b0);
    req[0] = 1'b0;
    tick(3);
    enable = 1'b1;

    // T5: silent writer, slot 11 (last valid) -> 0x580000; 1 + MAX_RETRY pulses.
    base = pulse_count;
    quad_mode = 1'b0;
    for (int i = 0; i <= MAX_RETRY; i++) exp_q.push_back({2'd2, 8'h03, 24'h580000});
    raise_req(2, 4'd11);
    tick(3);
    req[2] = 1'b0;
    wait_pulse(base + 1, HOLDOFF + 50, "t5_pulse1");
    wait_pulse(base + 2, ACK_TMO + 20, "t5_pulse2");
    wait_pulse(base + 3, ACK_TMO + 20, "t5_pulse3");
    if (pulse_count >= base + 3) begin
      check("t5_space12", pulse_cyc_q[base + 1] - pulse_cyc_q[base],     ACK_TMO + 1);
      check("t5_space23", pulse_cyc_q[base + 2] - pulse_cyc_q[base + 1], ACK_TMO + 1);
    end
    tick(ACK_TMO + 3);
    check("t5_err_timeout", err_timeout, 1'b1);
    check("t5_busy",        busy,        1'b1);
    check("t5_state_error", fsm_state,   ST_ERROR);
    check("t5_pulse_total", pulse_count, base + 3);
    raise_req(0, 4'd1);
    tick(6);
    req[0] = 1'b0;
    check("t5_error_holds", fsm_state, ST_ERROR);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    check("t5_tmo_clr",  err_timeout, 1'b0);
    check("t5_busy_clr", busy,        1'b0);
    check("t5_idle",     fsm_state,   ST_IDLE);

    // T6: reset during HOLDOFF aborts immediately; no pulse afterwards.
    base = pulse_count;
    raise_req(1, 4'd2);
    tick(3);
    req[1] = 1'b0;
    tick(100);
    check("t6_in_holdoff", fsm_state, ST_HOLDOFF);
    rst_n = 1'b0;
    #1;
    check("t6_rst_reboot", mbt_reboot, 1'b0);
    check("t6_rst_busy",   busy,       1'b0);
    check("t6_rst_addr",   spi_addr,   24'h0);
    check("t6_rst_opcode", spi_opcode, 8'h00);
    check("t6_rst_id",     grant_id,   2'd0);
    check("t6_rst_state",  fsm_state,  ST_IDLE);
    tick(2);
    rst_n = 1'b1;
    tick(HOLDOFF + 200);
    check("t6_no_pulse", pulse_count, base);

    // T7: a fresh request after reset is accepted; slot 1 quad -> 0x080000.
    base = pulse_count;
    quad_mode = 1'b1;
    exp_q.push_back({2'd0, 8'h6B, 24'h080000});
    raise_req(0, 4'd1);
    tick(3);
    req[0] = 1'b0;
    wait_pulse(base + 1, HOLDOFF + 50, "t7_pulse");
    respond(5, 20);
    tick(2);
    check("t7_idle", busy, 1'b0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
